// File: rtl/gray_rx_pkg.sv
// Shared definitions for the 3-bit Gray-code counter link (transmitter and receiver).
package gray_rx_pkg;

    localparam int GRAY_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        ERROR
    } rx_state_t;

    // Element i is the Gray code for count i: 000,001,011,010,110,111,101,100.
    localparam logic [7:0][GRAY_W-1:0] GRAY_SEQ = {
        3'b100, 3'b101, 3'b111, 3'b110, 3'b010, 3'b011, 3'b001, 3'b000
    };

endpackage

// File: rtl/gray_rx_gray2bin.sv
// Combinational Gray-to-binary decode: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    always_comb begin
        bin_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin_o[i] = ^(gray_i >> i);
        end
    end

endmodule

// File: rtl/gray_rx.sv
// Gray-code link receiver: decodes each accepted word, checks single forward steps and counts wraps.
module gray_rx
    import gray_rx_pkg::*;
#(
    parameter int WIDTH  = GRAY_W,
    parameter int WRAP_W = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              En,
    input  logic [WIDTH-1:0]  GrayIn,
    output logic [WIDTH-1:0]  Binary,
    output logic              Valid,
    output logic              StepErr,
    output logic              Overflow,
    output logic [WRAP_W-1:0] Wraps,
    output logic              Locked
);

    rx_state_t         state_q, state_d;
    logic [WIDTH-1:0]  binary_q, binary_d;
    logic              valid_q, valid_d;
    logic              stepErr_q, stepErr_d;
    logic              overflow_q, overflow_d;
    logic [WRAP_W-1:0] wraps_q, wraps_d;
    logic [WIDTH-1:0]  decoded;

    gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
        .gray_i(GrayIn),
        .bin_o (decoded)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            binary_q   <= '0;
            valid_q    <= 1'b0;
            stepErr_q  <= 1'b0;
            overflow_q <= 1'b0;
            wraps_q    <= '0;
        end else begin
            state_q    <= state_d;
            binary_q   <= binary_d;
            valid_q    <= valid_d;
            stepErr_q  <= stepErr_d;
            overflow_q <= overflow_d;
            wraps_q    <= wraps_d;
        end
    end

    // A wrap only counts when it is also a legal step; an illegal step that crosses 0 is just an error.
    always_comb begin
        state_d    = state_q;
        binary_d   = binary_q;
        valid_d    = 1'b0;
        stepErr_d  = stepErr_q;
        overflow_d = overflow_q;
        wraps_d    = wraps_q;
        case (state_q)
            IDLE: begin
                if (En) begin
                    binary_d = decoded;
                    valid_d  = 1'b1;
                    state_d  = TRACK;
                end
            end
            TRACK: begin
                if (En) begin
                    if (decoded == binary_q + WIDTH'(1)) begin
                        binary_d = decoded;
                        valid_d  = 1'b1;
                        if (binary_q == '1 && decoded == '0) begin
                            overflow_d = 1'b1;
                            if (wraps_q != '1) begin
                                wraps_d = wraps_q + WRAP_W'(1);
                            end
                        end
                    end else if (decoded != binary_q) begin
                        stepErr_d = 1'b1;
                        state_d   = ERROR;
                    end
                end
            end
            ERROR: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Binary   = binary_q;
    assign Valid    = valid_q;
    assign StepErr  = stepErr_q;
    assign Overflow = overflow_q;
    assign Wraps    = wraps_q;
    assign Locked   = (state_q == TRACK);

endmodule

// File: tb/tb_gray_rx.sv
// Randomized and directed checks of gray_rx against a table-lookup reference model.
module tb_gray_rx;
    import gray_rx_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       En = 1'b0;
    logic [2:0] GrayIn = 3'b000;

    logic [2:0] Binary, BinarySat;
    logic       Valid, ValidSat, StepErr, StepErrSat, Overflow, OverflowSat;
    logic       Locked, LockedSat;
    logic [3:0] Wraps;
    logic [1:0] WrapsSat;

    int vectorCount = 0;
    int miscompareCount = 0;

    rx_state_t modelState = IDLE;
    int modelBin = 0;
    int modelValid = 0;
    int modelErr = 0;
    int modelOvf = 0;
    int modelWraps = 0;
    int modelWrapsSat = 0;

    always #5 Clk = ~Clk;

    gray_rx #(.WIDTH(3), .WRAP_W(4)) dut (
        .Clk(Clk), .Reset(Reset), .En(En), .GrayIn(GrayIn),
        .Binary(Binary), .Valid(Valid), .StepErr(StepErr),
        .Overflow(Overflow), .Wraps(Wraps), .Locked(Locked)
    );

    gray_rx #(.WIDTH(3), .WRAP_W(2)) dutSat (
        .Clk(Clk), .Reset(Reset), .En(En), .GrayIn(GrayIn),
        .Binary(BinarySat), .Valid(ValidSat), .StepErr(StepErrSat),
        .Overflow(OverflowSat), .Wraps(WrapsSat), .Locked(LockedSat)
    );

    function automatic int grayToCount(input logic [2:0] g);
        for (int i = 0; i < 8; i++) begin
            if (GRAY_SEQ[i] == g) return i;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input int actual, input int expected);
        vectorCount++;
        if (actual != expected) begin
            miscompareCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Reference behaviour: counts are looked up in the Gray table, steps judged with modular arithmetic.
    task automatic modelEdge(input logic rst, input logic en, input logic [2:0] g);
        int d;
        modelValid = 0;
        if (rst) begin
            modelState = IDLE;
            modelBin = 0;
            modelErr = 0;
            modelOvf = 0;
            modelWraps = 0;
            modelWrapsSat = 0;
        end else if (en) begin
            d = grayToCount(g);
            if (modelState == IDLE) begin
                modelBin = d;
                modelValid = 1;
                modelState = TRACK;
            end else if (modelState == TRACK) begin
                if (d == (modelBin + 1) % 8) begin
                    if (modelBin == 7) begin
                        modelOvf = 1;
                        modelWraps = (modelWraps < 15) ? modelWraps + 1 : 15;
                        modelWrapsSat = (modelWrapsSat < 3) ? modelWrapsSat + 1 : 3;
                    end
                    modelBin = d;
                    modelValid = 1;
                end else if (d != modelBin) begin
                    modelErr = 1;
                    modelState = ERROR;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic [2:0] g);
        @(negedge Clk);
        Reset = rst;
        En = en;
        GrayIn = g;
        @(posedge Clk);
        modelEdge(rst, en, g);
        #1;
        checkOutput("Binary", int'(Binary), modelBin);
        checkOutput("Valid", int'(Valid), modelValid);
        checkOutput("StepErr", int'(StepErr), modelErr);
        checkOutput("Overflow", int'(Overflow), modelOvf);
        checkOutput("Wraps", int'(Wraps), modelWraps);
        checkOutput("Locked", int'(Locked), (modelState == TRACK) ? 1 : 0);
        checkOutput("WrapsSat", int'(WrapsSat), modelWrapsSat);
        checkOutput("StepErrSat", int'(StepErrSat), modelErr);
    endtask

    task automatic sendCount(input int c);
        logic [2:0] g;
        g = GRAY_SEQ[c % 8];
        applyStimulus(1'b0, 1'b1, g);
    endtask

    initial begin
        int r;
        logic [2:0] g;

        $display("[TB] full cycle");
        applyStimulus(1'b1, 1'b0, 3'b000);
        for (int i = 0; i <= 8; i++) sendCount(i);

        $display("[TB] stall and gaps");
        applyStimulus(1'b1, 1'b0, 3'b000);
        sendCount(0);
        applyStimulus(1'b0, 1'b0, 3'b111);
        sendCount(1);
        applyStimulus(1'b0, 1'b0, 3'b100);
        sendCount(2);
        applyStimulus(1'b0, 1'b0, 3'b000);
        sendCount(2);
        sendCount(2);

        $display("[TB] illegal jump");
        applyStimulus(1'b1, 1'b0, 3'b000);
        sendCount(0);
        sendCount(1);
        applyStimulus(1'b0, 1'b1, 3'b110);
        applyStimulus(1'b0, 1'b1, 3'b011);

        $display("[TB] backward step");
        applyStimulus(1'b1, 1'b0, 3'b000);
        sendCount(0);
        sendCount(1);
        sendCount(2);
        sendCount(1);

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 1'b0, 3'b000);
        for (int i = 0; i < 5; i++) sendCount(i);
        applyStimulus(1'b1, 1'b1, 3'b010);
        applyStimulus(1'b0, 1'b1, 3'b111);

        $display("[TB] wrap saturation");
        applyStimulus(1'b1, 1'b0, 3'b000);
        for (int i = 0; i <= 40; i++) sendCount(i);
        applyStimulus(1'b0, 1'b1, 3'b001);

        $display("[TB] random stream");
        applyStimulus(1'b1, 1'b0, 3'b000);
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 3 || (modelState == ERROR && r < 15)) begin
                g = 3'($urandom);
                applyStimulus(1'b1, 1'($urandom), g);
            end else if (r < 15) begin
                g = 3'($urandom);
                applyStimulus(1'b0, 1'b0, g);
            end else if (r < 25) begin
                sendCount(modelBin);
            end else if (r < 32) begin
                g = 3'($urandom);
                applyStimulus(1'b0, 1'b1, g);
            end else begin
                sendCount(modelBin + 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
